mips_lsu: RTL and testbench
===========================

Name: mips_lsu

Overview:
Load/store unit between the MIPS core datapath and the data memory port. It accepts one load or store request at a time and performs these functions:
- checks address alignment and raises address exceptions;
- builds the word address, byte enables and lane-replicated store data;
- runs a req/ack handshake with variable-latency memory, with a timeout;
- returns the sign- or zero-extended load result with a one-cycle done pulse.

Byte order is little-endian: byte 0 is bits [7:0].

Parameters:
TIMEOUT, 15, max cycles mem_req is held without mem_ack before a bus error (1..255)
CNT_W, 8, width of the wait-cycle counter

Ports:
clk  in  1  clock, rising edge
rst_b  in  1  asynchronous active-low reset
ls_valid  in  1  request strobe from core; sampled only in IDLE
ls_store  in  1  1 = store, 0 = load
ls_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
ls_unsigned  in  1  zero-extend loads (LBU/LHU); ignored for words and stores
ls_addr  in  32  effective byte address
ls_wdata  in  32  store data (rt)
ls_busy  out  1  request in flight (state != IDLE)
ls_done  out  1  one-cycle pulse: access complete, ls_rdata valid for loads
ls_rdata  out  32  extended load result, held until next accepted request
ls_adel  out  1  one-cycle pulse: misaligned load
ls_ades  out  1  one-cycle pulse: misaligned store
ls_dbe  out  1  one-cycle pulse: bus error (mem_excpt or timeout)
ls_bad_addr  out  32  faulting byte address, valid with any error pulse
mem_req  out  1  memory request
mem_addr  out  30  word address = ls_addr[31:2]
mem_data_in  out  32  store data, lane-replicated
mem_write_en  out  4  byte write mask
mem_ack  in  1  memory completes access this cycle
mem_data_out  in  32  read word, valid with mem_ack
mem_excpt  in  1  memory reports invalid address; valid with mem_ack

Behaviour:
- Reset (async, rst_b=0): state=IDLE.
  - All outputs 0: ls_busy, ls_done, ls_rdata, ls_adel, ls_ades, ls_dbe, ls_bad_addr, mem_req, mem_addr, mem_data_in, mem_write_en, counter.
  - mem_req drops immediately on reset assertion, even mid-access.
  - An in-flight access is abandoned; a late mem_ack is ignored.
- States: IDLE, REQ, RESP, ERR.
- IDLE, ls_valid=1: capture all request fields.
  - Misaligned access goes to ERR: half with addr[0]!=0, or word/reserved with addr[1:0]!=0.
  - Aligned access goes to REQ.
  - ls_valid in any other state is ignored (no queueing).
- REQ:
  - mem_req=1.
  - mem_addr, mem_data_in and mem_write_en are registered and stable for the whole state.
  - Counter increments each cycle without mem_ack.
  - mem_ack=1 with mem_excpt=0: latch data, go to RESP.
  - mem_ack=1 with mem_excpt=1: go to ERR (dbe).
  - Counter reaches TIMEOUT with no ack: go to ERR (dbe), mem_req deasserts.
  - mem_ack and timeout in the same cycle: ack wins.
- RESP: ls_done=1 for exactly one cycle, ls_rdata updated, then IDLE.
- ERR: exactly one of ls_adel/ls_ades/ls_dbe pulses for one cycle.
  - ls_bad_addr = captured ls_addr.
  - ls_done=0, ls_rdata unchanged.
  - Then IDLE.
- Latency: valid at edge N, mem_req high in cycle N+1. Ack in the first REQ cycle gives done in cycle N+2 (minimum). Misaligned access gives error pulse in cycle N+1 and never asserts mem_req.
- Store enables and data, where a = addr[1:0]:
  - byte: we = 4'b0001 << a, data = {4{wdata[7:0]}}
  - half: we = 4'b0011 (a=0) or 4'b1100 (a=2), data = {2{wdata[15:0]}}
  - word: we = 4'b1111, data = wdata
- Loads: mem_write_en=0 throughout. mem_write_en is also 0 whenever mem_req=0.
- Load extraction, lane selected by a:
  - byte = mem_data_out[8a+7:8a]
  - half = mem_data_out[16*a[1]+15 : 16*a[1]]
  - Sign-extend unless ls_unsigned=1; words pass through.
- ls_busy is 1 in REQ, RESP and ERR.

Test Plan:
- LW at 0x1000_0008, ack after 3 wait cycles, mem_data_out=0xDEADBEEF -> mem_addr=0x04000002, mem_write_en=0, ls_done one cycle, ls_rdata=0xDEADBEEF, mem_req high exactly 4 cycles.
- LB addr 0x...03, then LBU at the same address, mem_data_out=0x80FF7F01 -> ls_rdata=0xFFFFFF80 then 0x00000080. LH addr 0x...02, same word -> 0xFFFF80FF.
- SB addr 0x...01, wdata=0x123456AB -> mem_write_en=0010, mem_data_in=0xABABABAB. SH addr 0x...02 -> mem_write_en=1100, mem_data_in=0x56AB56AB.
- LW 0x...06 -> ls_adel pulse next cycle, ls_bad_addr=0x...06, mem_req never asserted. SH 0x...03 -> ls_ades pulse.
- TIMEOUT=15, mem_ack held 0 -> ls_dbe pulse after 15 REQ cycles, mem_req drops. Separately, ack with mem_excpt=1 -> ls_dbe, no ls_done.
- rst_b low mid-REQ -> mem_req=0 immediately, state IDLE. A later mem_ack produces no done. ls_valid pulses while busy are ignored (one done per accepted request).

Source files
------------

// File: rtl/mips_lsu_if.sv
// Core-side request/response and data-memory port signals of the load/store unit.
// The slave modport is the LSU itself; master is the core plus memory around it.
interface mips_lsu_if;
    logic        ls_valid;
    logic        ls_store;
    logic [1:0]  ls_size;
    logic        ls_unsigned;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_busy;
    logic        ls_done;
    logic [31:0] ls_rdata;
    logic        ls_adel;
    logic        ls_ades;
    logic        ls_dbe;
    logic [31:0] ls_bad_addr;
    logic        mem_req;
    logic [29:0] mem_addr;
    logic [31:0] mem_data_in;
    logic [3:0]  mem_write_en;
    logic        mem_ack;
    logic [31:0] mem_data_out;
    logic        mem_excpt;

    modport slave (
        input  ls_valid, ls_store, ls_size, ls_unsigned, ls_addr, ls_wdata,
        output ls_busy, ls_done, ls_rdata, ls_adel, ls_ades, ls_dbe, ls_bad_addr,
        output mem_req, mem_addr, mem_data_in, mem_write_en,
        input  mem_ack, mem_data_out, mem_excpt
    );

    modport master (
        output ls_valid, ls_store, ls_size, ls_unsigned, ls_addr, ls_wdata,
        input  ls_busy, ls_done, ls_rdata, ls_adel, ls_ades, ls_dbe, ls_bad_addr,
        input  mem_req, mem_addr, mem_data_in, mem_write_en,
        output mem_ack, mem_data_out, mem_excpt
    );
endinterface

// File: rtl/mips_lsu.sv
// MIPS load/store unit: one access at a time, done >= 2 cycles after accept, misalign error after 1.
// No queueing: ls_valid is ignored while busy; memory stalls via mem_ack with a TIMEOUT-cycle bus-error bound.
module mips_lsu #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 8
) (
    input  logic      clk,
    input  logic      rst_b,
    mips_lsu_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, RESP, ERR} state_t;

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

    state_t           state_q, state_d;
    logic             store_q, store_d;
    logic [1:0]       size_q, size_d;
    logic             uns_q, uns_d;
    logic [31:0]      addr_q, addr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dbe_q, dbe_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [31:0]      bad_q, bad_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       we_q, we_d;

    logic [3:0]       st_we;
    logic [31:0]      st_data;
    logic             misalign;
    logic [7:0]       ld_b;
    logic [15:0]      ld_h;
    logic [31:0]      ld_val;

    always_comb begin
        st_we   = 4'b1111;
        st_data = bus.ls_wdata;
        case (bus.ls_size)
            2'b00: begin
                st_we   = 4'b0001 << bus.ls_addr[1:0];
                st_data = {4{bus.ls_wdata[7:0]}};
            end
            2'b01: begin
                st_we   = bus.ls_addr[1] ? 4'b1100 : 4'b0011;
                st_data = {2{bus.ls_wdata[15:0]}};
            end
            default: ;
        endcase
        case (bus.ls_size)
            2'b00:   misalign = 1'b0;
            2'b01:   misalign = bus.ls_addr[0];
            default: misalign = (bus.ls_addr[1:0] != 2'b00);
        endcase
    end

    // Lane extraction from the captured address, applied to the word returned with mem_ack.
    always_comb begin
        case (addr_q[1:0])
            2'd0:    ld_b = bus.mem_data_out[7:0];
            2'd1:    ld_b = bus.mem_data_out[15:8];
            2'd2:    ld_b = bus.mem_data_out[23:16];
            default: ld_b = bus.mem_data_out[31:24];
        endcase
        ld_h = addr_q[1] ? bus.mem_data_out[31:16] : bus.mem_data_out[15:0];
        case (size_q)
            2'b00:   ld_val = uns_q ? {24'b0, ld_b} : {{24{ld_b[7]}}, ld_b};
            2'b01:   ld_val = uns_q ? {16'b0, ld_h} : {{16{ld_h[15]}}, ld_h};
            default: ld_val = bus.mem_data_out;
        endcase
    end

    always_comb begin
        state_d = state_q;
        store_d = store_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        dbe_d   = dbe_q;
        rdata_d = rdata_q;
        bad_d   = bad_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        case (state_q)
            IDLE: begin
                if (bus.ls_valid) begin
                    store_d = bus.ls_store;
                    size_d  = bus.ls_size;
                    uns_d   = bus.ls_unsigned;
                    addr_d  = bus.ls_addr;
                    cnt_d   = '0;
                    dbe_d   = 1'b0;
                    wdata_d = st_data;
                    we_d    = bus.ls_store ? st_we : 4'b0000;
                    if (misalign) begin
                        state_d = ERR;
                        bad_d   = bus.ls_addr;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                // An ack arriving on the timeout cycle still completes the access.
                if (bus.mem_ack) begin
                    if (bus.mem_excpt) begin
                        state_d = ERR;
                        dbe_d   = 1'b1;
                        bad_d   = addr_q;
                    end else begin
                        state_d = RESP;
                        if (!store_q) rdata_d = ld_val;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == TMO) begin
                        state_d = ERR;
                        dbe_d   = 1'b1;
                        bad_d   = addr_q;
                    end
                end
            end
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
            store_q <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            cnt_q   <= '0;
            dbe_q   <= 1'b0;
            rdata_q <= '0;
            bad_q   <= '0;
            wdata_q <= '0;
            we_q    <= 4'b0000;
        end else begin
            state_q <= state_d;
            store_q <= store_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            dbe_q   <= dbe_d;
            rdata_q <= rdata_d;
            bad_q   <= bad_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
        end
    end

    assign bus.mem_req      = (state_q == REQ);
    assign bus.mem_addr     = addr_q[31:2];
    assign bus.mem_data_in  = wdata_q;
    assign bus.mem_write_en = (state_q == REQ) ? we_q : 4'b0000;
    assign bus.ls_busy      = (state_q != IDLE);
    assign bus.ls_done      = (state_q == RESP);
    assign bus.ls_rdata     = rdata_q;
    assign bus.ls_adel      = (state_q == ERR) && !dbe_q && !store_q;
    assign bus.ls_ades      = (state_q == ERR) && !dbe_q && store_q;
    assign bus.ls_dbe       = (state_q == ERR) && dbe_q;
    assign bus.ls_bad_addr  = bad_q;
endmodule

// File: tb/tb_mips_lsu.sv
// Scoreboard bench for mips_lsu: each request pushes its expected outcome, a negedge monitor pops on every pulse.
module tb_mips_lsu;
    localparam int TMO = 15;

    logic clk   = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    mips_lsu_if bus();

    mips_lsu #(.TIMEOUT(TMO), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0]  kind;       // {done, adel, ades, dbe}
        logic [31:0] rdata;
        logic [31:0] bad;
        logic [29:0] maddr;
        logic [3:0]  we;
        logic [31:0] wd;
        logic        st;
        int          req_cycles;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [3:0]  obs_kind;
    int          n_vec = 0;
    int          n_miss = 0;
    int          req_cnt = 0;
    logic [31:0] last_rdata = '0;
    logic [31:0] last_bad = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ld_model(input logic [1:0] sz, input logic un,
                                             input logic [1:0] a, input logic [31:0] w);
        logic [31:0] sh;
        sh = w >> {a, 3'b000};
        case (sz)
            2'b00:   return {{24{~un & sh[7]}}, sh[7:0]};
            2'b01:   return {{16{~un & sh[15]}}, sh[15:0]};
            default: return w;
        endcase
    endfunction

    initial forever begin
        @(negedge clk);
        if (!rst_b) begin
            req_cnt = 0;
            sb.delete();
        end else begin
            if (bus.mem_req) begin
                req_cnt++;
                if (sb.size() > 0) begin
                    chk("mem_addr", {2'b00, bus.mem_addr}, {2'b00, sb[0].maddr});
                    chk("mem_we", {28'b0, bus.mem_write_en}, {28'b0, sb[0].st ? sb[0].we : 4'b0000});
                    if (sb[0].st) chk("mem_wdata", bus.mem_data_in, sb[0].wd);
                end else begin
                    chk("req_no_txn", {31'b0, bus.mem_req}, 32'd0);
                end
            end else begin
                chk("we_idle", {28'b0, bus.mem_write_en}, 32'd0);
            end
            obs_kind = {bus.ls_done, bus.ls_adel, bus.ls_ades, bus.ls_dbe};
            if (obs_kind != 4'b0000) begin
                if (sb.size() == 0) begin
                    chk("spurious_pulse", {28'b0, obs_kind}, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("pulse_kind", {28'b0, obs_kind}, {28'b0, mon_e.kind});
                    chk("ls_rdata", bus.ls_rdata, mon_e.rdata);
                    chk("ls_bad_addr", bus.ls_bad_addr, mon_e.bad);
                    chk("req_cycles", req_cnt, mon_e.req_cycles);
                end
                req_cnt = 0;
            end
        end
    end

    // dly < 0 means never acknowledge (timeout path).
    task automatic access(input logic st, input logic [1:0] sz, input logic un,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rword,
                          input int dly, input logic ex, input bit poke);
        exp_t e;
        bit   mis;
        int   guard;
        mis = (sz == 2'b01) ? a[0] : ((sz != 2'b00) && (a[1:0] != 2'b00));
        e.st    = st;
        e.maddr = a[31:2];
        case (sz)
            2'b00:   begin e.we = 4'b0001 << a[1:0];               e.wd = {4{wd[7:0]}};  end
            2'b01:   begin e.we = a[1] ? 4'b1100 : 4'b0011;        e.wd = {2{wd[15:0]}}; end
            default: begin e.we = 4'b1111;                         e.wd = wd;            end
        endcase
        e.rdata = last_rdata;
        e.bad   = last_bad;
        if (mis) begin
            e.kind = st ? 4'b0010 : 4'b0100;
            e.bad = a;
            e.req_cycles = 0;
        end else if (dly < 0) begin
            e.kind = 4'b0001;
            e.bad = a;
            e.req_cycles = TMO;
        end else if (ex) begin
            e.kind = 4'b0001;
            e.bad = a;
            e.req_cycles = dly + 1;
        end else begin
            e.kind = 4'b1000;
            e.req_cycles = dly + 1;
            if (!st) e.rdata = ld_model(sz, un, a[1:0], rword);
        end
        last_rdata = e.rdata;
        last_bad   = e.bad;
        sb.push_back(e);

        bus.ls_valid    = 1'b1;
        bus.ls_store    = st;
        bus.ls_size     = sz;
        bus.ls_unsigned = un;
        bus.ls_addr     = a;
        bus.ls_wdata    = wd;
        @(negedge clk);
        bus.ls_valid = 1'b0;
        if (!mis && dly >= 0) begin
            for (int i = 0; i < dly; i++) begin
                if (poke && i == 0) begin
                    bus.ls_valid = 1'b1;
                    bus.ls_addr  = a ^ 32'h0000_0040;
                    bus.ls_store = ~st;
                end else begin
                    bus.ls_valid = 1'b0;
                end
                @(negedge clk);
            end
            bus.ls_valid     = 1'b0;
            bus.mem_ack      = 1'b1;
            bus.mem_data_out = rword;
            bus.mem_excpt    = ex;
            @(negedge clk);
            bus.mem_ack      = 1'b0;
            bus.mem_excpt    = 1'b0;
            bus.mem_data_out = $urandom;
        end
        guard = 0;
        while (bus.ls_busy && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        chk("busy_bound", {31'b0, bus.ls_busy}, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        exp_t e;
        bus.ls_valid = 0; bus.ls_store = 0; bus.ls_size = 0; bus.ls_unsigned = 0;
        bus.ls_addr = 0; bus.ls_wdata = 0;
        bus.mem_ack = 0; bus.mem_data_out = 0; bus.mem_excpt = 0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'b0, bus.ls_busy}, 32'd0);
        chk("rst_req", {31'b0, bus.mem_req}, 32'd0);
        chk("rst_pulses", {28'b0, bus.ls_done, bus.ls_adel, bus.ls_ades, bus.ls_dbe}, 32'd0);
        chk("rst_rdata", bus.ls_rdata, 32'd0);
        chk("rst_bad", bus.ls_bad_addr, 32'd0);
        chk("rst_maddr", {2'b00, bus.mem_addr}, 32'd0);
        chk("rst_mdata", bus.mem_data_in, 32'd0);
        chk("rst_we", {28'b0, bus.mem_write_en}, 32'd0);
        rst_b = 1'b1;
        @(negedge clk);

        // Loads: word with wait states, then byte/half lanes with sign and zero extension.
        access(0, 2'b10, 0, 32'h1000_0008, 0, 32'hDEAD_BEEF, 3, 0, 0);
        access(0, 2'b00, 0, 32'h1000_0003, 0, 32'h80FF_7F01, 0, 0, 0);
        access(0, 2'b00, 1, 32'h1000_0003, 0, 32'h80FF_7F01, 1, 0, 0);
        access(0, 2'b01, 0, 32'h1000_0002, 0, 32'h80FF_7F01, 0, 0, 0);
        access(0, 2'b01, 1, 32'h1000_0000, 0, 32'h80FF_7F01, 2, 0, 0);
        access(0, 2'b00, 0, 32'h1000_0001, 0, 32'h80FF_7F01, 0, 0, 0);
        access(0, 2'b11, 0, 32'h2000_0004, 0, 32'h0123_4567, 0, 0, 0);
        // Stores: lane enables and replicated data; ls_rdata must stay put.
        access(1, 2'b00, 0, 32'h1000_0001, 32'h1234_56AB, 0, 1, 0, 0);
        access(1, 2'b01, 0, 32'h1000_0002, 32'h1234_56AB, 0, 0, 0, 0);
        access(1, 2'b10, 0, 32'h1000_0010, 32'hCAFE_F00D, 0, 2, 0, 0);
        // Misaligned accesses.
        access(0, 2'b10, 0, 32'h1000_0006, 0, 0, 0, 0, 0);
        access(1, 2'b01, 0, 32'h1000_0003, 32'h5555_AAAA, 0, 0, 0, 0);
        access(0, 2'b01, 0, 32'h1000_0001, 0, 0, 0, 0, 0);
        access(1, 2'b11, 0, 32'h1000_0002, 0, 0, 0, 0, 0);
        // Bus errors: timeout and memory exception.
        access(0, 2'b10, 0, 32'h3000_0000, 0, 0, -1, 0, 0);
        access(1, 2'b10, 0, 32'h3000_0004, 32'h1111_2222, 0, 2, 1, 0);
        access(0, 2'b10, 0, 32'h3000_0008, 0, 32'h7777_8888, TMO - 1, 0, 0);
        // Request strobed while busy must be ignored.
        access(0, 2'b10, 0, 32'h4000_0000, 0, 32'hA5A5_5A5A, 4, 0, 1);

        // Reset in the middle of REQ; a late ack must not complete anything.
        e.kind = 4'b1000; e.rdata = 0; e.bad = 0; e.maddr = 30'h0140_0001;
        e.we = 0; e.wd = 0; e.st = 0; e.req_cycles = 0;
        sb.push_back(e);
        bus.ls_valid = 1; bus.ls_store = 0; bus.ls_size = 2'b10; bus.ls_addr = 32'h0500_0004;
        @(negedge clk);
        bus.ls_valid = 0;
        @(negedge clk);
        chk("pre_rst_req", {31'b0, bus.mem_req}, 32'd1);
        rst_b = 1'b0;
        #1;
        chk("rst_mid_req", {31'b0, bus.mem_req}, 32'd0);
        chk("rst_mid_busy", {31'b0, bus.ls_busy}, 32'd0);
        last_rdata = '0;
        last_bad   = '0;
        repeat (2) @(negedge clk);
        #1 rst_b = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1; bus.mem_data_out = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("late_ack_done", {31'b0, bus.ls_done}, 32'd0);
        end
        bus.mem_ack = 0;
        @(negedge clk);

        // Random mix.
        for (int n = 0; n < 30; n++) begin
            logic [31:0] ra;
            logic [1:0]  rsz;
            rsz = 2'($urandom_range(0, 3));
            ra  = $urandom;
            if ($urandom_range(0, 3) != 0) ra[1:0] = (rsz == 2'b00) ? ra[1:0] : (rsz == 2'b01) ? {ra[1], 1'b0} : 2'b00;
            access(1'($urandom_range(0, 1)), rsz, 1'($urandom_range(0, 1)), ra, $urandom, $urandom,
                   $urandom_range(0, 5), ($urandom_range(0, 7) == 0), 0);
        end

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
